// File: rtl/ipv4_addr_cam_if.sv
// ipv4_addr_cam_if: the register bus and lookup/result signals of ipv4_addr_cam.
//   register bus : rd / wr / clr level requests, each with a one-cycle ack
//   lookup       : i_daddr / i_daddr_valid in, o_daddr_ready back
//   result FIFO  : o_is_local / o_match_idx / o_result_valid out, i_result_rd pop
//   statistics   : o_hit_cnt / o_miss_cnt
// master = requester (host / packet path), slave = the CAM.
interface ipv4_addr_cam_if #(
  parameter int ROW_BITS = 5
) ();
  logic                i_rd_req;
  logic                o_rd_ack;
  logic [ROW_BITS-1:0] i_rd_addr;
  logic [31:0]         o_rd_ipv4_addr;
  logic [31:0]         o_rd_mask;
  logic                o_rd_entry_valid;
  logic                i_wr_req;
  logic                o_wr_ack;
  logic [ROW_BITS-1:0] i_wr_addr;
  logic [31:0]         i_wr_ipv4_addr;
  logic [31:0]         i_wr_mask;
  logic                i_wr_entry_valid;
  logic                i_clr_req;
  logic                o_clr_ack;
  logic [31:0]         i_daddr;
  logic                i_daddr_valid;
  logic                o_daddr_ready;
  logic                o_is_local;
  logic [ROW_BITS-1:0] o_match_idx;
  logic                o_result_valid;
  logic                i_result_rd;
  logic [31:0]         o_hit_cnt;
  logic [31:0]         o_miss_cnt;

  modport master (
    output i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_ipv4_addr, i_wr_mask,
           i_wr_entry_valid, i_clr_req, i_daddr, i_daddr_valid, i_result_rd,
    input  o_rd_ack, o_rd_ipv4_addr, o_rd_mask, o_rd_entry_valid, o_wr_ack, o_clr_ack,
           o_daddr_ready, o_is_local, o_match_idx, o_result_valid, o_hit_cnt, o_miss_cnt
  );

  modport slave (
    input  i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_ipv4_addr, i_wr_mask,
           i_wr_entry_valid, i_clr_req, i_daddr, i_daddr_valid, i_result_rd,
    output o_rd_ack, o_rd_ipv4_addr, o_rd_mask, o_rd_entry_valid, o_wr_ack, o_clr_ack,
           o_daddr_ready, o_is_local, o_match_idx, o_result_valid, o_hit_cnt, o_miss_cnt
  );
endinterface

// File: rtl/ipv4_addr_cam.sv
// ipv4_addr_cam: IPv4 local/prefix match table with a banked 3-stage lookup
// pipeline, credit-based backpressure, a fallthrough result FIFO and hit/miss
// counters.
// Ports:
//   Bus2IP_Clk : single clock for everything
//   reset      : synchronous, active-high
//   bus        : ipv4_addr_cam_if.slave (register bus, lookup, results, counters)

// One compare bank: masked match of BANK_SIZE rows, lowest hitting row wins.
module ipv4_addr_cam_bank #(
  parameter int BANK_SIZE = 8,
  parameter int IDX_BITS  = 3
) (
  input  logic [31:0]                daddr,
  input  logic [BANK_SIZE-1:0][31:0] addr,
  input  logic [BANK_SIZE-1:0][31:0] mask,
  input  logic [BANK_SIZE-1:0]       valid,
  output logic                       hit,
  output logic [IDX_BITS-1:0]        idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    // descending scan so the lowest matching row is the last one written
    for (int i = BANK_SIZE-1; i >= 0; i--)
      if (valid[i] && ((daddr & mask[i]) == (addr[i] & mask[i]))) begin
        hit = 1'b1;
        idx = IDX_BITS'(i);
      end
  end
endmodule

module ipv4_addr_cam #(
  parameter int ROWS           = 32,
  parameter int ROW_BITS       = 5,
  parameter int BANK_SIZE      = 8,
  parameter int OUT_DEPTH_BITS = 2,
  parameter int MASK_EN        = 1
) (
  input logic            Bus2IP_Clk,
  input logic            reset,
  ipv4_addr_cam_if.slave bus
);
  localparam int NB    = ROWS / BANK_SIZE;
  localparam int LB    = (BANK_SIZE > 1) ? $clog2(BANK_SIZE) : 1;
  localparam int DEPTH = 2 ** OUT_DEPTH_BITS;
  localparam int UW    = OUT_DEPTH_BITS + 2;
  localparam int EW    = 1 + ROW_BITS;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_CLEAR} state_t;
  typedef enum logic [1:0] {K_RD, K_WR, K_CLR} kind_t;

  state_t              state, state_d;
  kind_t               kind, kind_d;
  logic                rd_go, wr_go, clr_go;
  logic [ROW_BITS-1:0] clr_row;

  logic [ROWS-1:0][31:0] tbl_addr, tbl_mask;
  logic [ROWS-1:0]       tbl_vld;

  logic [31:0] rd_addr_q, rd_mask_q;
  logic        rd_vld_q;

  // ---------------- control FSM ----------------
  always_comb begin
    state_d = state;
    kind_d  = kind;
    rd_go   = 1'b0;
    wr_go   = 1'b0;
    clr_go  = 1'b0;
    case (state)
      S_IDLE:
        if (bus.i_clr_req) begin
          clr_go = 1'b1; kind_d = K_CLR; state_d = S_CLEAR;
        end else if (bus.i_rd_req) begin
          rd_go = 1'b1; kind_d = K_RD; state_d = S_ACK;
        end else if (bus.i_wr_req) begin
          wr_go = 1'b1; kind_d = K_WR; state_d = S_ACK;
        end
      S_CLEAR: if (clr_row == ROW_BITS'(ROWS-1)) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (reset) begin
      state   <= S_IDLE;
      kind    <= K_RD;
      clr_row <= '0;
    end else begin
      state   <= state_d;
      kind    <= kind_d;
      clr_row <= (state == S_CLEAR) ? clr_row + ROW_BITS'(1) : '0;
    end
  end

  assign bus.o_rd_ack  = (state == S_ACK) && (kind == K_RD);
  assign bus.o_wr_ack  = (state == S_ACK) && (kind == K_WR);
  assign bus.o_clr_ack = (state == S_ACK) && (kind == K_CLR);

  // ---------------- table ----------------
  logic wr_in_range, rd_in_range;
  assign wr_in_range = int'(bus.i_wr_addr) < ROWS;
  assign rd_in_range = int'(bus.i_rd_addr) < ROWS;

  always_ff @(posedge Bus2IP_Clk) begin
    if (reset) begin
      tbl_vld  <= '0;
      tbl_addr <= '0;
      tbl_mask <= '1;
    end else if (state == S_CLEAR) begin
      tbl_vld[clr_row]  <= 1'b0;
      tbl_addr[clr_row] <= '0;
      tbl_mask[clr_row] <= '1;
    end else if (wr_go && wr_in_range) begin
      tbl_vld[bus.i_wr_addr]  <= bus.i_wr_entry_valid;
      tbl_addr[bus.i_wr_addr] <= bus.i_wr_ipv4_addr;
      // exact-match builds store an all-ones mask so the compare needs no mux
      tbl_mask[bus.i_wr_addr] <= (MASK_EN != 0) ? bus.i_wr_mask : '1;
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (reset) begin
      rd_addr_q <= '0;
      rd_mask_q <= '0;
      rd_vld_q  <= 1'b0;
    end else if (rd_go) begin
      rd_addr_q <= rd_in_range ? tbl_addr[bus.i_rd_addr] : '0;
      rd_mask_q <= rd_in_range ? tbl_mask[bus.i_rd_addr] : '0;
      rd_vld_q  <= rd_in_range && tbl_vld[bus.i_rd_addr];
    end
  end

  assign bus.o_rd_ipv4_addr   = rd_addr_q;
  assign bus.o_rd_mask        = rd_mask_q;
  assign bus.o_rd_entry_valid = rd_vld_q;

  // ---------------- lookup pipeline ----------------
  logic [1:0]               vld_pipe;   // [0] = S1 holds daddr, [1] = S2 holds bank results
  logic [31:0]              s1_daddr;
  logic [NB-1:0]            bank_hit, s2_hit;
  logic [NB-1:0][LB-1:0]    bank_idx, s2_idx;
  logic                     s3_hit;
  logic [ROW_BITS-1:0]      s3_idx;
  logic [OUT_DEPTH_BITS:0]  fifo_cnt;
  logic [UW-1:0]            credits_used;
  logic                     clr_busy, accept, push, pop;

  // a completed clear keeps lookups out through its ack cycle
  assign clr_busy     = (state == S_CLEAR) || ((state == S_ACK) && (kind == K_CLR));
  assign credits_used = UW'(fifo_cnt) + UW'(vld_pipe[0]) + UW'(vld_pipe[1]);
  assign bus.o_daddr_ready = !reset && !clr_busy && (credits_used < UW'(DEPTH));
  assign accept       = bus.i_daddr_valid && bus.o_daddr_ready;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    ipv4_addr_cam_bank #(.BANK_SIZE(BANK_SIZE), .IDX_BITS(LB)) u_bank (
      .daddr (s1_daddr),
      .addr  (tbl_addr[b*BANK_SIZE +: BANK_SIZE]),
      .mask  (tbl_mask[b*BANK_SIZE +: BANK_SIZE]),
      .valid (tbl_vld[b*BANK_SIZE +: BANK_SIZE]),
      .hit   (bank_hit[b]),
      .idx   (bank_idx[b])
    );
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (reset) begin
      vld_pipe <= '0;
      s1_daddr <= '0;
      s2_hit   <= '0;
      s2_idx   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], accept};
      if (accept) s1_daddr <= bus.i_daddr;
      s2_hit <= bank_hit;
      s2_idx <= bank_idx;
    end
  end

  // S3: lowest hitting bank wins
  always_comb begin
    s3_hit = 1'b0;
    s3_idx = '0;
    for (int b = NB-1; b >= 0; b--)
      if (s2_hit[b]) begin
        s3_hit = 1'b1;
        s3_idx = ROW_BITS'(b*BANK_SIZE) + ROW_BITS'(s2_idx[b]);
      end
  end

  // ---------------- result FIFO (fallthrough) ----------------
  logic [DEPTH-1:0][EW-1:0]  fifo_mem;
  logic [OUT_DEPTH_BITS-1:0] wr_ptr, rd_ptr;

  assign push = vld_pipe[1];   // credits guarantee room
  assign pop  = bus.i_result_rd && (fifo_cnt != '0);

  always_ff @(posedge Bus2IP_Clk)
    if (push) fifo_mem[wr_ptr] <= {s3_hit, s3_idx};

  always_ff @(posedge Bus2IP_Clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + OUT_DEPTH_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + OUT_DEPTH_BITS'(1);
      fifo_cnt <= fifo_cnt + (OUT_DEPTH_BITS+1)'(push) - (OUT_DEPTH_BITS+1)'(pop);
    end
  end

  assign {bus.o_is_local, bus.o_match_idx} = fifo_mem[rd_ptr];
  assign bus.o_result_valid = (fifo_cnt != '0);

  // ---------------- counters ----------------
  logic [31:0] hit_cnt, miss_cnt;

  always_ff @(posedge Bus2IP_Clk) begin
    if (reset || clr_go) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (push) begin
      if (s3_hit) hit_cnt  <= hit_cnt + 32'd1;
      else        miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.o_hit_cnt  = hit_cnt;
  assign bus.o_miss_cnt = miss_cnt;
endmodule

// File: tb/tb_ipv4_addr_cam.sv
// Self-checking bench for ipv4_addr_cam: directed steps plus randomized
// lookups checked against a linear-search reference table.
module tb_ipv4_addr_cam;
  localparam int ROWS = 32;
  localparam int ROW_BITS = 5;

  logic Bus2IP_Clk = 1'b0;
  logic reset = 1'b1;
  always #5 Bus2IP_Clk = ~Bus2IP_Clk;

  ipv4_addr_cam_if #(.ROW_BITS(ROW_BITS)) bus ();

  ipv4_addr_cam #(.ROWS(ROWS), .ROW_BITS(ROW_BITS), .BANK_SIZE(8),
                  .OUT_DEPTH_BITS(2), .MASK_EN(1)) dut (
    .Bus2IP_Clk(Bus2IP_Clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  logic [31:0] m_addr [ROWS];
  logic [31:0] m_mask [ROWS];
  logic        m_vld  [ROWS];
  logic [5:0]  exp_q[$];
  int unsigned m_hit = 0, m_miss = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] model_lookup(input logic [31:0] d);
    for (int r = 0; r < ROWS; r++)
      if (m_vld[r] && ((d & m_mask[r]) == (m_addr[r] & m_mask[r]))) return {1'b1, 5'(r)};
    return 6'd0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++) begin
      m_addr[r] = '0; m_mask[r] = '1; m_vld[r] = 1'b0;
    end
    m_hit = 0; m_miss = 0;
  endtask

  // one clock; scoreboards pops and accepted lookups seen at this edge
  task automatic tick();
    logic acc, pop;
    logic [31:0] d;
    logic [5:0] head, r;
    acc  = bus.i_daddr_valid && bus.o_daddr_ready;
    pop  = bus.i_result_rd && bus.o_result_valid;
    d    = bus.i_daddr;
    head = {bus.o_is_local, bus.o_match_idx};
    @(posedge Bus2IP_Clk); #1;
    if (pop) begin
      chk("result_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("result", 64'(head), 64'(exp_q.pop_front()));
    end
    if (acc) begin
      r = model_lookup(d);
      exp_q.push_back(r);
      if (r[5]) m_hit++; else m_miss++;
      acc_cnt++;
    end
  endtask

  task automatic do_write(input int row, input logic [31:0] a, input logic [31:0] m, input logic v);
    int n;
    n = 0;
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 5'(row);
    bus.i_wr_ipv4_addr = a; bus.i_wr_mask = m; bus.i_wr_entry_valid = v;
    do begin tick(); n++; end while (!bus.o_wr_ack && n < 50);
    chk("wr_ack", 64'(bus.o_wr_ack), 64'd1);
    m_addr[row] = a; m_mask[row] = m; m_vld[row] = v;
    bus.i_wr_req = 1'b0;
    tick();
  endtask

  task automatic do_read(input int row);
    int n;
    n = 0;
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 5'(row);
    do begin tick(); n++; end while (!bus.o_rd_ack && n < 50);
    chk("rd_ack", 64'(bus.o_rd_ack), 64'd1);
    chk("rd_addr", 64'(bus.o_rd_ipv4_addr), 64'(m_addr[row]));
    chk("rd_mask", 64'(bus.o_rd_mask), 64'(m_mask[row]));
    chk("rd_valid", 64'(bus.o_rd_entry_valid), 64'(m_vld[row]));
    bus.i_rd_req = 1'b0;
    tick();
  endtask

  task automatic lookup(input logic [31:0] d);
    int base, n;
    base = acc_cnt; n = 0;
    bus.i_daddr = d; bus.i_daddr_valid = 1'b1;
    do begin tick(); n++; end while (acc_cnt == base && n < 50);
    bus.i_daddr_valid = 1'b0;
    chk("lookup_accepted", 64'(acc_cnt - base), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.i_result_rd = 1'b1;
    while ((exp_q.size() != 0 || bus.o_result_valid) && n < 60) begin tick(); n++; end
    bus.i_result_rd = 1'b0;
    chk("drain_done", 64'(exp_q.size() == 0 && !bus.o_result_valid), 64'd1);
    chk("hit_cnt", 64'(bus.o_hit_cnt), 64'(m_hit));
    chk("miss_cnt", 64'(bus.o_miss_cnt), 64'(m_miss));
  endtask

  task automatic lookup_obs(input logic [31:0] d, output logic [5:0] res);
    int n;
    n = 0;
    bus.i_result_rd = 1'b0;
    lookup(d);
    while (!bus.o_result_valid && n < 10) begin tick(); n++; end
    res = {bus.o_is_local, bus.o_match_idx};
    drain();
  endtask

  task automatic do_clear();
    int n;
    logic low;
    n = 0; low = 1'b1;
    bus.i_clr_req = 1'b1;
    tick(); n++;
    model_clear();
    while (!bus.o_clr_ack && n < 100) begin
      if (bus.o_daddr_ready) low = 1'b0;
      tick(); n++;
    end
    if (bus.o_daddr_ready) low = 1'b0;
    chk("clr_ack_latency", 64'(n), 64'(ROWS + 1));
    chk("clr_ready_low", 64'(low), 64'd1);
    chk("clr_hit_zero", 64'(bus.o_hit_cnt), 64'd0);
    chk("clr_miss_zero", 64'(bus.o_miss_cnt), 64'd0);
    bus.i_clr_req = 1'b0;
    tick();
    chk("clr_ready_back", 64'(bus.o_daddr_ready), 64'd1);
  endtask

  initial begin
    logic [5:0] res;
    logic [31:0] stream [6];
    logic [31:0] pool [8];
    int k, base, n, len, ord;
    logic [31:0] mk;

    bus.i_rd_req = 0; bus.i_rd_addr = 0; bus.i_wr_req = 0; bus.i_wr_addr = 0;
    bus.i_wr_ipv4_addr = 0; bus.i_wr_mask = 0; bus.i_wr_entry_valid = 0;
    bus.i_clr_req = 0; bus.i_daddr = 0; bus.i_daddr_valid = 0; bus.i_result_rd = 0;
    model_clear();

    // reset state
    reset = 1'b1;
    repeat (3) tick();
    chk("ready_in_reset", 64'(bus.o_daddr_ready), 64'd0);
    reset = 1'b0;
    tick();
    chk("rst_ready", 64'(bus.o_daddr_ready), 64'd1);
    chk("rst_result_valid", 64'(bus.o_result_valid), 64'd0);
    chk("rst_hit", 64'(bus.o_hit_cnt), 64'd0);
    chk("rst_miss", 64'(bus.o_miss_cnt), 64'd0);
    chk("rst_rd_data", 64'({bus.o_rd_ipv4_addr, bus.o_rd_mask}), 64'd0);
    chk("rst_acks", 64'({bus.o_rd_ack, bus.o_wr_ack, bus.o_clr_ack, bus.o_rd_entry_valid}), 64'd0);
    do_read(7);

    // exact hit with A+3 latency, then a miss
    do_write(3, 32'h0A000001, 32'hFFFFFFFF, 1'b1);
    bus.i_daddr = 32'h0A000001; bus.i_daddr_valid = 1'b1;
    tick();
    bus.i_daddr_valid = 1'b0;
    chk("lat_a1_valid", 64'(bus.o_result_valid), 64'd0);
    tick();
    chk("lat_a2_valid", 64'(bus.o_result_valid), 64'd0);
    tick();
    chk("lat_a3_valid", 64'(bus.o_result_valid), 64'd1);
    chk("lat_a3_head", 64'({bus.o_is_local, bus.o_match_idx}), 64'({1'b1, 5'd3}));
    chk("lat_a3_hit_cnt", 64'(bus.o_hit_cnt), 64'd1);
    drain();
    lookup_obs(32'h0A000002, res);
    chk("miss_head", 64'(res), 64'd0);
    chk("miss_cnt_1", 64'(bus.o_miss_cnt), 64'd1);

    // prefixes across banks
    do_write(9, 32'hC0A80000, 32'hFFFF0000, 1'b1);
    do_write(17, 32'hC0A80100, 32'hFFFFFF00, 1'b1);
    lookup_obs(32'hC0A80105, res);
    chk("prefix_lowest", 64'(res), 64'({1'b1, 5'd9}));
    do_write(9, 32'hC0A80000, 32'hFFFF0000, 1'b0);
    lookup_obs(32'hC0A80105, res);
    chk("prefix_after_inval", 64'(res), 64'({1'b1, 5'd17}));

    // backpressure: no pops, 4 credits
    stream[0] = 32'h0A000001; stream[1] = 32'hC0A80105; stream[2] = 32'h08080808;
    stream[3] = 32'hC0A8FF01; stream[4] = 32'h0A000001; stream[5] = 32'h01020304;
    bus.i_result_rd = 1'b0;
    base = acc_cnt; k = 0;
    bus.i_daddr = stream[0]; bus.i_daddr_valid = 1'b1;
    repeat (8) begin
      tick();
      if (acc_cnt - base > k) begin k++; bus.i_daddr = stream[k]; end
    end
    chk("bp_accepted", 64'(acc_cnt - base), 64'd4);
    chk("bp_ready_low", 64'(bus.o_daddr_ready), 64'd0);
    chk("bp_fifo_valid", 64'(bus.o_result_valid), 64'd1);
    bus.i_result_rd = 1'b1;
    tick();
    bus.i_result_rd = 1'b0;
    chk("bp_ready_after_pop", 64'(bus.o_daddr_ready), 64'd1);
    tick();
    chk("bp_fifth_accepted", 64'(acc_cnt - base), 64'd5);
    bus.i_daddr_valid = 1'b0;
    drain();

    // coherency: lookup at W-1 misses, lookup at W sees the write at W
    bus.i_daddr = 32'h01020304; bus.i_daddr_valid = 1'b1;
    tick();
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 5'd0; bus.i_wr_ipv4_addr = 32'h01020304;
    bus.i_wr_mask = 32'hFFFFFFFF; bus.i_wr_entry_valid = 1'b1;
    m_addr[0] = 32'h01020304; m_mask[0] = 32'hFFFFFFFF; m_vld[0] = 1'b1;
    base = m_hit;
    tick();
    bus.i_daddr_valid = 1'b0;
    chk("coh_wr_ack", 64'(bus.o_wr_ack), 64'd1);
    bus.i_wr_req = 1'b0;
    tick();
    drain();
    chk("coh_one_hit", 64'(int'(m_hit) - base), 64'd1);

    // randomized tables and streams
    pool[0] = 32'h0A000000; pool[1] = 32'hC0A80000; pool[2] = 32'hAC100000; pool[3] = 32'h08080800;
    pool[4] = 32'h01020300; pool[5] = 32'hC0A80100; pool[6] = 32'h0A000100; pool[7] = 32'hFFFFFC00;
    for (int round = 0; round < 3; round++) begin
      for (int w = 0; w < 10; w++) begin
        len = int'($urandom_range(8, 32));
        mk = ~(32'hFFFFFFFF >> len);
        do_write(int'($urandom % 32), pool[$urandom % 8] | ($urandom & 32'h3FF), mk,
                 1'(($urandom % 4) != 0));
      end
      for (int c = 0; c < 120; c++) begin
        bus.i_daddr_valid = 1'(($urandom % 4) != 0);
        bus.i_daddr = pool[$urandom % 8] | ($urandom & 32'h3FF);
        bus.i_result_rd = 1'(($urandom % 3) != 0);
        tick();
      end
      bus.i_daddr_valid = 1'b0;
      drain();
    end

    // fill, then clear-all
    for (int r = 0; r < ROWS; r++) do_write(r, 32'h0B000000 | r, 32'hFFFFFFFF, 1'b1);
    lookup_obs(32'h0B000005, res);
    chk("full_hit5", 64'(res), 64'({1'b1, 5'd5}));
    lookup_obs(32'h0B00001F, res);
    chk("full_hit31", 64'(res), 64'({1'b1, 5'd31}));
    do_clear();
    lookup(32'h0B000005);
    lookup(32'h0B00001F);
    drain();
    chk("post_clr_hit", 64'(bus.o_hit_cnt), 64'd0);
    chk("post_clr_miss", 64'(bus.o_miss_cnt), 64'd2);

    // arbitration clr > rd > wr
    do_write(17, 32'h11111111, 32'hFFFFFFFF, 1'b1);
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 5'd17;
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 5'd5; bus.i_wr_ipv4_addr = 32'h05050505;
    bus.i_wr_mask = 32'hFFFFFF00; bus.i_wr_entry_valid = 1'b1;
    bus.i_clr_req = 1'b1;
    ord = 0; n = 0;
    while ((bus.i_rd_req || bus.i_wr_req || bus.i_clr_req) && n < 200) begin
      tick(); n++;
      if (bus.o_clr_ack) begin ord = ord * 4 + 1; bus.i_clr_req = 1'b0; model_clear(); end
      if (bus.o_rd_ack) begin
        ord = ord * 4 + 2; bus.i_rd_req = 1'b0;
        chk("arb_rd_addr", 64'(bus.o_rd_ipv4_addr), 64'(m_addr[17]));
        chk("arb_rd_valid", 64'(bus.o_rd_entry_valid), 64'(m_vld[17]));
      end
      if (bus.o_wr_ack) begin
        ord = ord * 4 + 3; bus.i_wr_req = 1'b0;
        m_addr[5] = 32'h05050505; m_mask[5] = 32'hFFFFFF00; m_vld[5] = 1'b1;
      end
    end
    tick();
    chk("arb_order", 64'(ord), 64'd27);
    do_read(5);
    do_read(17);

    // reset during CLEAR with a lookup in flight
    bus.i_result_rd = 1'b0;
    lookup(32'h05050577);
    bus.i_clr_req = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("rst2_ready_low", 64'(bus.o_daddr_ready), 64'd0);
    tick();
    reset = 1'b0;
    bus.i_clr_req = 1'b0;
    exp_q.delete();
    model_clear();
    tick();
    chk("rst2_result_valid", 64'(bus.o_result_valid), 64'd0);
    chk("rst2_counters", 64'({bus.o_hit_cnt, bus.o_miss_cnt}), 64'd0);
    chk("rst2_acks", 64'({bus.o_rd_ack, bus.o_wr_ack, bus.o_clr_ack}), 64'd0);
    chk("rst2_rd_data", 64'({bus.o_rd_ipv4_addr, bus.o_rd_mask}), 64'd0);
    chk("rst2_ready", 64'(bus.o_daddr_ready), 64'd1);
    tick();
    chk("rst2_still_empty", 64'(bus.o_result_valid), 64'd0);
    do_read(5);
    lookup_obs(32'h05050505, res);
    chk("rst2_table_reinit", 64'(res), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
